// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, coordinates, registered syncs and blanked colour.
// Optional macro VGA_RGB_REG_EN registers colour and delays syncs by one pixel for pin alignment.
module vga_timing_gen #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic        p_tick,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [11:0] rgb_out
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DivW-1:0] DivLast    = DivW'(DIV - 1);
    localparam logic [9:0]      HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0]      VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0]      HSyncStart = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]      HSyncEnd   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0]      VSyncStart = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]      VSyncEnd   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            hs_q, hs_d, vs_q, vs_d;
    logic            tick;

    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + DivW'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == HLast) begin
                x_d = '0;
                y_d = (y_q == VLast) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs decoded from the next coordinates so the registers line up with pix_x/pix_y.
        hs_d = !((x_d >= HSyncStart) && (x_d <= HSyncEnd));
        vs_d = !((y_d >= VSyncStart) && (y_d <= VSyncEnd));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign p_tick     = tick & ~reset;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign video_on   = (x_q < 10'(H_DISPLAY)) && (y_q < 10'(V_DISPLAY));
    assign frame_tick = p_tick && (x_q == HLast) && (y_q == VLast);

`ifdef VGA_RGB_REG_EN
    logic [11:0] rgb_q;
    logic        hs_dly_q, vs_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q    <= '0;
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else if (tick) begin
            rgb_q    <= video_on ? rgb_in : 12'h000;
            hs_dly_q <= hs_q;
            vs_dly_q <= vs_q;
        end
    end

    assign hsync   = hs_dly_q;
    assign vsync   = vs_dly_q;
    assign rgb_out = reset ? 12'h000 : rgb_q;
`else
    assign hsync   = hs_q;
    assign vsync   = vs_q;
    assign rgb_out = (video_on && !reset) ? rgb_in : 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: a small raster geometry checked every clock against an arithmetic model
// that derives position from the clock count since reset release.
module tb_vga_timing_gen;

    localparam int unsigned DIV = 4;
    localparam int unsigned HD = 16, HFP = 3, HS = 4, HBP = 2;
    localparam int unsigned VD = 6, VFP = 2, VS = 2, VBP = 1;
    localparam int unsigned HT = HD + HFP + HS + HBP;
    localparam int unsigned VT = VD + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic        p_tick, video_on, hsync, vsync, frame_tick;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] rgb_out;

    vga_timing_gen #(
        .DIV(DIV), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(p_tick), .pix_x(pix_x),
        .pix_y(pix_y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .frame_tick(frame_tick), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned ph_of(input int unsigned tt);
        return tt % DIV;
    endfunction
    function automatic int unsigned x_of(input int unsigned tt);
        return (tt / DIV) % HT;
    endfunction
    function automatic int unsigned y_of(input int unsigned tt);
        return (tt / DIV / HT) % VT;
    endfunction
    function automatic bit vis_of(input int unsigned tt);
        return (x_of(tt) < HD) && (y_of(tt) < VD);
    endfunction
    function automatic bit hs_of(input int unsigned tt);
        return !((x_of(tt) >= HD + HFP) && (x_of(tt) < HD + HFP + HS));
    endfunction
    function automatic bit vs_of(input int unsigned tt);
        return !((y_of(tt) >= VD + VFP) && (y_of(tt) < VD + VFP + VS));
    endfunction

    int unsigned t = 0;
    int unsigned obs_frames = 0;
    int unsigned exp_frames = 0;
    logic [11:0] reg_rgb = 12'h000;
    bit          reg_hs = 1'b1;
    bit          reg_vs = 1'b1;

    initial begin
        bit          ex_pt, ex_ft, ex_hs, ex_vs;
        logic [11:0] ex_rgb;
        for (int cyc = 0; cyc < 4200; cyc++) begin
            @(posedge clk);
            if (reset) begin
                t       = 0;
                reg_rgb = 12'h000;
                reg_hs  = 1'b1;
                reg_vs  = 1'b1;
            end else begin
                if (ph_of(t) == DIV - 1) begin
                    reg_rgb = vis_of(t) ? rgb_in : 12'h000;
                    reg_hs  = hs_of(t);
                    reg_vs  = vs_of(t);
                end
                t++;
            end
            #1;
            reset  = (cyc < 3) || (cyc == 2600) || ($urandom_range(0, 1499) == 0);
            rgb_in = ($urandom_range(0, 3) == 0) ? 12'hfff : 12'($urandom);
            #3;
            ex_pt = !reset && (ph_of(t) == DIV - 1);
            ex_ft = ex_pt && (x_of(t) == HT - 1) && (y_of(t) == VT - 1);
`ifdef VGA_RGB_REG_EN
            ex_hs  = reg_hs;
            ex_vs  = reg_vs;
            ex_rgb = reset ? 12'h000 : reg_rgb;
`else
            ex_hs  = hs_of(t);
            ex_vs  = vs_of(t);
            ex_rgb = (!reset && vis_of(t)) ? rgb_in : 12'h000;
`endif
            check_eq("p_tick", 32'(p_tick), 32'(ex_pt));
            check_eq("pix_x", 32'(pix_x), x_of(t));
            check_eq("pix_y", 32'(pix_y), y_of(t));
            check_eq("video_on", 32'(video_on), 32'(vis_of(t)));
            check_eq("hsync", 32'(hsync), 32'(ex_hs));
            check_eq("vsync", 32'(vsync), 32'(ex_vs));
            check_eq("frame_tick", 32'(frame_tick), 32'(ex_ft));
            check_eq("rgb_out", 32'(rgb_out), 32'(ex_rgb));
            if (frame_tick === 1'b1) obs_frames++;
            if (ex_ft) exp_frames++;
        end
        check_eq("frame_count", obs_frames, exp_frames);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter DIV, default 4: system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
REQ-002 SHALL have parameter H_DISPLAY, default 640: visible pixels per line.
REQ-003 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels.
REQ-004 SHALL have parameter V_DISPLAY, default 480: visible lines per frame.
REQ-005 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync and back porch in lines.
REQ-006 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rgb_in  input  12  pixel colour from the graphics unit, 4:4:4.
REQ-009 SHALL have port p_tick  output  1  one-clk pixel strobe.
REQ-010 SHALL have port pix_x  output  10  current column, 0..H_TOTAL-1.
REQ-011 SHALL have port pix_y  output  10  current line, 0..V_TOTAL-1.
REQ-012 SHALL have port video_on  output  1  high while pix_x<H_DISPLAY and pix_y<V_DISPLAY.
REQ-013 SHALL have ports hsync and vsync  output  1 each  active-low sync pulses to the connector.
REQ-014 SHALL have port frame_tick  output  1  one-clk strobe at end of frame.
REQ-015 SHALL have port rgb_out  output  12  blanked colour to the DAC pins.

Function
REQ-016 SHALL derive H_TOTAL=H_DISPLAY+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL likewise (default 525).
REQ-017 SHALL run divider counter 0..DIV-1, wrapping; p_tick high for exactly the clk in which the counter equals DIV-1; DIV=1 -> p_tick continuously high outside reset.
REQ-018 SHALL update pix_x only on the edge ending a p_tick cycle: pix_x==H_TOTAL-1 -> 0, else +1.
REQ-019 SHALL update pix_y only when p_tick and pix_x==H_TOTAL-1: pix_y==V_TOTAL-1 -> 0, else +1.
REQ-020 SHALL register hsync, computed from the next pix_x, so hsync==0 exactly while pix_x in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] (default 656..751), with zero skew to pix_x.
REQ-021 SHALL register vsync likewise: 0 exactly while pix_y in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] (default 490..491).
REQ-022 SHALL decode video_on combinationally from pix_x/pix_y.
REQ-023 SHALL assert frame_tick for one clk when p_tick, pix_x==H_TOTAL-1 and pix_y==V_TOTAL-1; never otherwise.
REQ-024 SHALL make every (pix_x,pix_y) pair, including (0,481), persist for exactly DIV clks, so consumers decoding a single coordinate get a one-pixel-wide event.
REQ-025 SHALL drive rgb_out = video_on ? rgb_in : 12'h000 (blanking mandatory).

Reset
REQ-026 SHALL on reset force divider=0, pix_x=0, pix_y=0, hsync=1, vsync=1, p_tick=0, frame_tick=0, rgb_out=0.
REQ-027 SHALL honour reset mid-frame: all state zeroed on the next edge, first p_tick exactly DIV clks after the first clk with reset low.
REQ-028 SHALL give reset priority over p_tick on the same edge.

Configuration
REQ-029 SHALL support macro VGA_RGB_REG_EN.
REQ-030 SHALL with VGA_RGB_REG_EN defined register rgb_out on p_tick and delay hsync/vsync by one pixel period, keeping colour and sync aligned at the pins (one-pixel pipeline latency).
REQ-031 SHALL without VGA_RGB_REG_EN drive rgb_out combinationally per REQ-025, with syncs as in REQ-020/021.

Verification
REQ-032 SHALL cover: reset released, DIV=4 -> p_tick on clks 4,8,12...; pix_x 0->1 on clk 4 edge; outputs per REQ-026 during reset.
REQ-033 SHALL cover: one full line -> hsync low for exactly 96 pixels starting pix_x=656; pix_x wraps 799->0 while pix_y increments.
REQ-034 SHALL cover: one full frame -> vsync low on lines 490,491 only; exactly one frame_tick per 800*525*4=1,680,000 clks.
REQ-035 SHALL cover: rgb_in=12'hfff constant -> rgb_out 12'hfff at (639,479), 12'h000 at (640,0) and (0,480).
REQ-036 SHALL cover: reset asserted at pix_x=300, pix_y=200 for one clk -> next state (0,0), hsync=vsync=1, first p_tick 4 clks later.
REQ-037 SHALL cover: VGA_RGB_REG_EN defined -> rgb_out and hsync falling edge both lag combinational build by one pixel (4 clks).
